hilo_muldiv_ctrl: RTL

Iterative multiply/divide controller that owns the HI and LO architectural registers feeding the operand-2 selector in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from decode, sequences a 32-step shift-add multiplier or restoring divider, and commits the results to HI/LO. While an operation is in flight, it stalls the pipeline on any HI/LO read or on a new HI/LO command.

---
 rtl/hilo_muldiv_ctrl_if.sv | 23 ++
 rtl/hilo_muldiv_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// HI/LO multiply/divide controller bus: decode-side command and EX-side results.
interface hilo_muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output op_valid, op, rs_val, rt_val, mf_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, mf_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI and LO.
module hilo_muldiv_ctrl (
    input logic               clk,
    input logic               reset,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic        div_q, div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        sgn, is_mul, is_div, is_mthi, is_mtlo, busy, hilo_op;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sum33, rem33;
    logic [31:0] diff32;
    logic        ge;
    logic [63:0] prod_n;

    assign busy    = state_q != S_IDLE;
    assign hilo_op = bus.op_valid && bus.op != 3'd0 && bus.op != 3'd7;
    assign is_mul  = bus.op_valid && (bus.op == OP_MULT || bus.op == OP_MULTU);
    assign is_div  = bus.op_valid && (bus.op == OP_DIV || bus.op == OP_DIVU);
    assign is_mthi = bus.op_valid && bus.op == OP_MTHI;
    assign is_mtlo = bus.op_valid && bus.op == OP_MTLO;
    assign sgn     = bus.op == OP_MULT || bus.op == OP_DIV;

    assign a_mag = (sgn && bus.rs_val[31]) ? (~bus.rs_val + 32'd1) : bus.rs_val;
    assign b_mag = (sgn && bus.rt_val[31]) ? (~bus.rt_val + 32'd1) : bus.rt_val;

    assign sum33  = {1'b0, acc_q[63:32]} + {1'b0, mcand_q};
    // remainder after the left shift can reach 33 bits before the trial subtract
    assign rem33  = acc_q[63:31];
    assign ge     = rem33 >= {1'b0, mcand_q};
    assign diff32 = rem33[31:0] - mcand_q;
    assign prod_n = ~acc_q + 64'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    is_mul: begin
                        acc_d   = {32'd0, b_mag};
                        mcand_d = a_mag;
                        neg_d   = sgn && (bus.rs_val[31] ^ bus.rt_val[31]);
                        rneg_d  = 1'b0;
                        div_d   = 1'b0;
                        cnt_d   = 5'd0;
                        state_d = S_MUL;
                    end
                    is_div: begin
                        div_d = 1'b1;
                        cnt_d = 5'd0;
                        if (bus.rt_val == 32'd0) begin
                            acc_d   = {bus.rs_val, 32'hFFFF_FFFF};
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = S_FIX;
                        end else begin
                            acc_d   = {32'd0, a_mag};
                            mcand_d = b_mag;
                            neg_d   = sgn && (bus.rs_val[31] ^ bus.rt_val[31]);
                            rneg_d  = sgn && bus.rs_val[31];
                            state_d = S_DIV;
                        end
                    end
                    is_mthi: hi_d = bus.rs_val;
                    is_mtlo: lo_d = bus.rs_val;
                    default: ;
                endcase
            end
            S_MUL: begin
                acc_d = acc_q[0] ? {sum33, acc_q[31:1]}
                                 : {1'b0, acc_q[63:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = ge ? {diff32, acc_q[30:0], 1'b1}
                           : {acc_q[62:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    hi_d = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                    lo_d = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                end else begin
                    hi_d = neg_q ? prod_n[63:32] : acc_q[63:32];
                    lo_d = neg_q ? prod_n[31:0] : acc_q[31:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            mcand_q <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.stall = busy && (bus.mf_req || hilo_op);
endmodule
